// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared accelerator FSM encoding and default BRAM geometry
package accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10
    } acc_state_t;

    localparam int ACC_W          = 8;
    localparam int ACC_ADDR_WIDTH = 18;

endpackage

// File: rtl/bram_result_writer.sv
// rtl/bram_result_writer.sv - serialises a captured flat vector into consecutive BRAM words
module bram_result_writer
    import accel_pkg::*;
#(
    parameter int NUM_ELEMS  = 8,
    parameter int W          = ACC_W,
    parameter int ADDR_WIDTH = ACC_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_ELEMS*W-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic                   bram_gnt,
    output logic                   bram_en,
    output logic                   bram_wen,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [W-1:0]           bram_din,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    acc_state_t             state;
    logic [IDX_W-1:0]       idx;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [NUM_ELEMS*W-1:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            addr_reg <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg    <= data_in;
                        addr_reg <= base_addr;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Without a grant everything holds; the arbiter may stall us indefinitely.
                    if (bram_gnt) begin
                        shreg    <= shreg >> W;
                        addr_reg <= addr_reg + ADDR_WIDTH'(1);
                        idx      <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Enable follows the grant combinationally so a write lands on the granted edge.
    assign bram_en   = (state == ST_WRITE) && bram_gnt;
    assign bram_wen  = (state == ST_WRITE) && bram_gnt;
    assign bram_addr = addr_reg;
    assign bram_din  = shreg[W-1:0];

endmodule

// File: tb/tb_bram_result_writer.sv
// tb/tb_bram_result_writer.sv - directed self-checking bench for bram_result_writer
module tb_bram_result_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] data_in;
    logic [17:0] base_addr;
    logic        gnt;
    logic        bram_en, bram_wen, busy, done;
    logic [17:0] bram_addr;
    logic [7:0]  bram_din;

    logic        start1;
    logic [7:0]  data1;
    logic [17:0] base1;
    logic        en1, wen1, busy1, done1;
    logic [17:0] addr1;
    logic [7:0]  din1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_result_writer #(.NUM_ELEMS(8), .W(8), .ADDR_WIDTH(18)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .base_addr(base_addr), .bram_gnt(gnt), .bram_en(bram_en),
        .bram_wen(bram_wen), .bram_addr(bram_addr), .bram_din(bram_din),
        .busy(busy), .done(done)
    );

    bram_result_writer #(.NUM_ELEMS(1), .W(8), .ADDR_WIDTH(18)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data1),
        .base_addr(base1), .bram_gnt(gnt), .bram_en(en1),
        .bram_wen(wen1), .bram_addr(addr1), .bram_din(din1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle start is high; cycle c is c edges later.
    task automatic run_txn(input string tag, input logic [17:0] base, input logic [63:0] vec,
                           input logic [63:0] low_mask, input bit inject, input int exp_done,
                           output logic [17:0] a2, output logic [17:0] a3);
        int n = 0;
        int dc = -1;
        logic [17:0] ea;
        a2 = '0;
        a3 = '0;
        start = 1'b1; base_addr = base; data_in = vec; gnt = 1'b1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            gnt   = !low_mask[c];
            start = inject && (c == 3);
            if (inject && c == 3) begin
                data_in   = ~vec;
                base_addr = 18'd5;
            end
            #1;
            check({tag, " en"}, {63'd0, bram_en}, {63'd0, gnt && !done});
            check({tag, " wen"}, {63'd0, bram_wen}, {63'd0, gnt && !done});
            if (bram_en && n < 8) begin
                ea = base + 18'(n);
                check({tag, " addr"}, {46'd0, bram_addr}, {46'd0, ea});
                check({tag, " din"}, {56'd0, bram_din}, {56'd0, vec[n*8 +: 8]});
                if (n == 2) a2 = bram_addr;
                if (n == 3) a3 = bram_addr;
                n++;
            end
            if (done) begin
                dc = c;
                break;
            end
            tick();
        end
        start = 1'b0;
        check({tag, " done_cycle"}, 64'(dc), 64'(exp_done));
        check({tag, " n_writes"}, 64'(n), 64'd8);
        tick();
        check({tag, " done_single"}, {63'd0, done}, 64'd0);
        check({tag, " busy_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [17:0] a2, a3;
        rst_n = 1'b0; start = 1'b0; data_in = '0; base_addr = '0; gnt = 1'b1;
        start1 = 1'b0; data1 = '0; base1 = '0;
        tick();
        tick();
        check("rst en", {63'd0, bram_en}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst addr", {46'd0, bram_addr}, 64'd0);
        check("rst din", {56'd0, bram_din}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle no activity", {63'd0, bram_en}, 64'd0);

        run_txn("basic", 18'd100, 64'h0807060504030201, 64'd0, 1'b0, 9, a2, a3);
        check("basic a3", {46'd0, a3}, 64'd103);

        // Issued straight from the IDLE cycle that follows done.
        run_txn("stall", 18'd100, 64'h0807060504030201, 64'h18, 1'b0, 11, a2, a3);

        run_txn("wrap", 18'd262141, 64'h8877665544332211, 64'd0, 1'b0, 9, a2, a3);
        check("wrap a2", {46'd0, a2}, 64'd262143);
        check("wrap a3", {46'd0, a3}, 64'd0);

        run_txn("inject", 18'd40, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b1, 9, a2, a3);
        tick();
        tick();
        check("inject no second busy", {63'd0, busy}, 64'd0);
        check("inject no second en", {63'd0, bram_en}, 64'd0);

        // Reset after the fourth write.
        start = 1'b1; base_addr = 18'd200; data_in = 64'h1122334455667788; gnt = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        check("prerst en", {63'd0, bram_en}, 64'd1);
        check("prerst addr", {46'd0, bram_addr}, 64'd204);
        rst_n = 1'b0;
        #1;
        check("midrst en", {63'd0, bram_en}, 64'd0);
        check("midrst wen", {63'd0, bram_wen}, 64'd0);
        check("midrst busy", {63'd0, busy}, 64'd0);
        check("midrst done", {63'd0, done}, 64'd0);
        check("midrst addr", {46'd0, bram_addr}, 64'd0);
        check("midrst din", {56'd0, bram_din}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("postrst en", {63'd0, bram_en}, 64'd0);
        check("postrst busy", {63'd0, busy}, 64'd0);
        check("postrst done", {63'd0, done}, 64'd0);
        run_txn("postrst", 18'd200, 64'h0F1E2D3C4B5A6978, 64'd0, 1'b0, 9, a2, a3);

        // Single-element instance at the top of the address space.
        start1 = 1'b1; base1 = 18'h3FFFF; data1 = 8'hA5; gnt = 1'b1;
        tick();
        start1 = 1'b0;
        check("one en", {63'd0, en1}, 64'd1);
        check("one addr", {46'd0, addr1}, 64'h3FFFF);
        check("one din", {56'd0, din1}, 64'hA5);
        tick();
        check("one done", {63'd0, done1}, 64'd1);
        check("one en_done", {63'd0, en1}, 64'd0);
        tick();
        check("one done_single", {63'd0, done1}, 64'd0);
        check("one busy_idle", {63'd0, busy1}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_result_writer.md
BRAM_RESULT_WRITER -- requirements
Module: bram_result_writer

Interface
REQ-001 Parameter NUM_ELEMS, 8, number of W-bit elements written per transaction (>=1).
REQ-002 Parameter W, 8, element width in bits; equals the BRAM data width.
REQ-003 Parameter ADDR_WIDTH, 18, BRAM address width.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 start  input  1  request to write one flat vector; sampled only in IDLE.
REQ-007 data_in  input  NUM_ELEMS*W  flat vector; element i occupies bits [i*W +: W].
REQ-008 base_addr  input  ADDR_WIDTH  BRAM address of element 0; sampled with start.
REQ-009 bram_gnt  input  1  arbiter grant; write port usable this cycle when high.
REQ-010 bram_en  output  1  BRAM enable.
REQ-011 bram_wen  output  1  BRAM write enable.
REQ-012 bram_addr  output  ADDR_WIDTH  BRAM address.
REQ-013 bram_din  output  W  BRAM write data.
REQ-014 busy  output  1  high in WRITE and DONE states.
REQ-015 done  output  1  single-cycle pulse after the last element is written.

Function
REQ-016 FSM states: IDLE, WRITE, DONE; IDLE is the reset state.
REQ-017 IDLE, start=1: capture data_in into an internal shift register, load addr_reg<=base_addr, idx<=0, go to WRITE; start=0: stay.
REQ-018 start in WRITE or DONE is ignored; no queuing; data_in/base_addr changes after capture have no effect.
REQ-019 bram_en = bram_wen = (state==WRITE) && bram_gnt, combinational; low in every other state.
REQ-020 bram_addr = addr_reg and bram_din = low W bits of the shift register, driven from registers in all states.
REQ-021 WRITE, bram_gnt=1: write occurs on that edge; idx+1, addr_reg+1, shift register right by W.
REQ-022 WRITE, bram_gnt=0: hold idx, addr_reg, shift register; no write; no timeout.
REQ-023 WRITE, bram_gnt=1 and idx==NUM_ELEMS-1: go to DONE on that edge.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 Minimum latency start-to-done is NUM_ELEMS+1 cycles (gnt held high); each gnt-low cycle in WRITE adds one.
REQ-026 Address arithmetic is modulo 2^ADDR_WIDTH; base_addr near top wraps to 0 without error.
REQ-027 Element i is written to address (base_addr+i) mod 2^ADDR_WIDTH, exactly once per transaction.
REQ-028 NUM_ELEMS=1: single write cycle, then DONE.
REQ-029 Back-to-back: start high in the cycle after done is accepted (IDLE) and begins a new transaction.

Reset
REQ-030 rst_n=0 immediately forces IDLE, idx=0, addr_reg=0, shift register=0, done=0, busy=0, bram_en=bram_wen=0, bram_addr=0, bram_din=0.
REQ-031 Reset mid-WRITE aborts the transaction; no further writes; partially written addresses are not restored.
REQ-032 After rst_n rises, no activity until a new start.

Structure
REQ-033 State encoding (2-bit IDLE=00, WRITE=01, DONE=10) and the default W/ADDR_WIDTH constants live in the shared accelerator package used by the weight loaders.
REQ-034 Single flat module; no sub-module; BRAM is external, reached through the bram_* ports so readers and this writer share it via the arbiter.

Verification
REQ-035 NUM_ELEMS=8, gnt=1, base_addr=100, data_in bytes 0x01..0x08 -> writes addr 100..107 data 0x01..0x08 on consecutive cycles; done 9 cycles after start.
REQ-036 Same, gnt low on cycles 3 and 4 of WRITE -> en/wen low those cycles, no address skipped or duplicated; done at cycle 11.
REQ-037 base_addr=2^18-3 -> addresses 262141, 262142, 262143, 0, 1, ...; all 8 bytes correct.
REQ-038 Change data_in and pulse start mid-WRITE -> written data matches captured vector; exactly one done; no second transaction.
REQ-039 rst_n low after 4th write -> en/wen drop asynchronously, busy=0, no done; subsequent start writes full vector correctly.
REQ-040 Write vector with this block, then read back through weight loader at same base -> loader output equals data_in.
